pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Sequencer that configures the pwm block: accepts a target duty-cycle request and steps duty_cycle_val toward it, one step per PWM period boundary, issuing single-cycle load pulses. Gives soft-start and soft-change so the PWM output never jumps directly between large duty values. Sits between the software/control interface and the pwm block's load/duty_cycle_val inputs.

Parameters:
PERIOD, 100, clocks per PWM period; internal tick generated every PERIOD cycles.
HOLD_PERIODS, 1, PWM periods between consecutive duty updates (>=1).
MAX_DUTY, 100, upper clamp for any duty value (<=255).

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous active-low reset.
req_valid  input  1  new target request present.
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
req_target  input  8  requested final duty value.
req_step  input  8  increment per update; 0 treated as 1.
load  output  1  one-cycle pulse to pwm block, duty_cycle_val valid same cycle.
duty_cycle_val  output  8  duty value presented to pwm block; held between loads.
busy  output  1  high in RAMP and DONE.
done  output  1  one-cycle pulse when target reached.

Behaviour:
- Reset (rst low, asynchronous): load=0, duty_cycle_val=0, busy=0, done=0, state=IDLE so req_ready=1; period and hold counters cleared.
- Period counter: free-running 0..PERIOD-1 from reset release; tick when count==PERIOD-1; wraps to 0.
- States: IDLE, RAMP, DONE.
- IDLE: on accept, capture tgt=min(req_target, MAX_DUTY), stp=max(req_step,1), clear hold counter. If tgt==duty_cycle_val -> DONE, no load. Else -> RAMP.
- RAMP: on each tick increment hold counter; when hold counter==HOLD_PERIODS-1 on a tick, compute next and clear hold counter. Cycle after that tick: duty_cycle_val<=next, load=1 for exactly one cycle. When next==tgt -> DONE.
- Arithmetic in 9 bits, no wrap: up: next = (cur+stp >= tgt) ? tgt : cur+stp. Down: next = (cur <= tgt+stp) ? tgt : cur-stp. Final value is always exactly tgt.
- DONE: lasts one cycle, done=1, busy=1, then IDLE. done is the cycle after the final load (or cycle after accept when no ramp needed).
- req_valid while not IDLE is ignored (req_ready=0); request is not queued.
- Period counter is not reset by requests; first update lands on the first qualifying tick after accept (latency up to HOLD_PERIODS*PERIOD cycles).
- load is never asserted outside RAMP; at most one load per PERIOD*HOLD_PERIODS cycles.
- Reset mid-ramp: all outputs return to reset values immediately; captured target discarded.

Optional Feature:
PWM_RAMP_ABORT_EN: adds input port abort (1 bit). In RAMP, abort high -> IDLE next cycle, no further load, duty_cycle_val held at last loaded value, done not asserted. In IDLE/DONE abort has no effect. Without the macro the port does not exist and every accepted ramp runs to completion.

Test Plan:
- Reset: hold rst=0 20 cycles then release -> load=0, duty_cycle_val=0, busy=0, done=0, req_ready=1; no load for 1000 cycles idle.
- Up-ramp (PERIOD=100, HOLD=1): from 0 request target=20 step=5 -> loads 5,10,15,20 exactly 100 cycles apart; done one cycle after the load of 20; req_ready returns 1 next cycle.
- Down-ramp non-divisible: from 20 request target=3 step=7 -> loads 13,6,3; done after 3; no underflow.
- Clamp/zero step: from 3 request target=150 step=200 -> single load of 100; then target=102 step=0 -> no load, done next cycle after accept (clamped 100==current).
- Busy rejection and hold: HOLD_PERIODS=2, target=75 step=25 from 0 -> loads 25,50,75 each 200 cycles apart; req_valid pulses with target=10 during ramp are ignored, final duty 75.
- Reset mid-ramp and abort: assert rst=0 after second load of a 0->75 ramp -> duty_cycle_val=0 immediately; with PWM_RAMP_ABORT_EN, abort after load of 50 -> no further load, duty stays 50, done stays 0, req_ready=1.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the pwm block's duty_cycle_val toward a requested target, one step per
// HOLD_PERIODS PWM periods. Define PWM_RAMP_ABORT_EN to add the abort input.
module pwm_ramp_ctrl #(
  parameter int PERIOD       = 100,
  parameter int HOLD_PERIODS = 1,
  parameter int MAX_DUTY     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_target,
  input  logic [7:0] req_step,
`ifdef PWM_RAMP_ABORT_EN
  input  logic       abort,
`endif
  output logic       load,
  output logic [7:0] duty_cycle_val,
  output logic       busy,
  output logic       done
);

  localparam int            CW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int            HW        = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);
  localparam logic [7:0]    MAX_VAL   = 8'(MAX_DUTY);

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic [7:0]    tgt, stp, tgt_in, stp_in, next_val;
  logic [8:0]    sum, lim;
  logic          tick, accept, update, last, abort_i;

`ifdef PWM_RAMP_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign tick      = (cnt == CNT_LAST);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = req_valid && req_ready;
  assign tgt_in    = (req_target > MAX_VAL) ? MAX_VAL : req_target;
  assign stp_in    = (req_step == 8'd0) ? 8'd1 : req_step;
  assign update    = (state == RAMP) && tick && (hold == HOLD_LAST) && !abort_i;

  // 9-bit sums so a step can never wrap past 0 or 255 before the clamp to tgt.
  assign sum = {1'b0, duty_cycle_val} + {1'b0, stp};
  assign lim = {1'b0, tgt} + {1'b0, stp};

  always_comb begin
    // NOTE: default first, so every path assigns next_val and no latch is inferred.
    next_val = tgt;
    if (tgt > duty_cycle_val) begin
      if (sum < {1'b0, tgt}) next_val = sum[7:0];
    end else if ({1'b0, duty_cycle_val} > lim) begin
      next_val = duty_cycle_val - stp;
    end
  end

  // Free-running period counter; requests never realign it.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) cnt <= '0;
    else      cnt <= tick ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (tgt_in == duty_cycle_val) ? DONE : RAMP;
      RAMP: begin
        if (abort_i)          state_next = IDLE;
        else if (load && last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The load pulse and the new duty value appear together in the cycle after
  // the qualifying tick; `last` marks that this load reaches the target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt            <= '0;
      stp            <= '0;
      hold           <= '0;
      duty_cycle_val <= '0;
      load           <= 1'b0;
      last           <= 1'b0;
    end else begin
      load <= update;
      if (accept) begin
        tgt  <= tgt_in;
        stp  <= stp_in;
        hold <= '0;
        last <= 1'b0;
      end else if ((state == RAMP) && tick) begin
        hold <= (hold == HOLD_LAST) ? '0 : hold + 1'b1;
      end
      if (update) begin
        duty_cycle_val <= next_val;
        last           <= (next_val == tgt);
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: two instances (HOLD_PERIODS 1 and 2)
// checked every cycle against a precomputed load timeline per request.
module tb_pwm_ramp_ctrl;

  localparam int P    = 100;
  localparam int MAXD = 100;
  localparam int NS   = 128;

  typedef struct {
    int              inst;
    int              tgt;
    int              stp;
    int              n;
    logic [3:0][7:0] loads;
    int              fin;
    bit              poke;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rv[2];
  logic [7:0] rt, rs;
  logic       abort;
  logic       ready[2], load[2], busy[2], done[2];
  logic [7:0] duty[2];

  pwm_ramp_ctrl #(.PERIOD(P), .HOLD_PERIODS(1), .MAX_DUTY(MAXD)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(ready[0]),
    .req_target(rt), .req_step(rs),
`ifdef PWM_RAMP_ABORT_EN
    .abort(abort),
`endif
    .load(load[0]), .duty_cycle_val(duty[0]), .busy(busy[0]), .done(done[0])
  );

  pwm_ramp_ctrl #(.PERIOD(P), .HOLD_PERIODS(2), .MAX_DUTY(MAXD)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(ready[1]),
    .req_target(rt), .req_step(rs),
`ifdef PWM_RAMP_ABORT_EN
    .abort(abort),
`endif
    .load(load[1]), .duty_cycle_val(duty[1]), .busy(busy[1]), .done(done[1])
  );

  always #5 clk = ~clk;

  // Reference model: each accepted request becomes a list of (cycle, value)
  // loads plus busy/done windows, all measured in cycles since reset release.
  int cyc, nchk, nerr;
  int sch_cyc[2][NS];
  int sch_val[2][NS];
  int sch_n[2], sch_k[2];
  int m_duty[2], busy_from[2], busy_to[2], ramp_to[2], done_cyc[2];
  int obs[2][16];
  int nobs[2];
  bit done_seen[2];

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit m_busy(input int i, input int c);
    return (c >= busy_from[i]) && (c <= busy_to[i]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sch_n[i] = 0; sch_k[i] = 0; m_duty[i] = 0;
      busy_from[i] = 0; busy_to[i] = -1; ramp_to[i] = -1; done_cyc[i] = -1;
    end
  endtask

  task automatic model_accept(input int i, input int a, input int t_req, input int s_req);
    int tgt, stp, v, t0, n;
    tgt = (t_req > MAXD) ? MAXD : t_req;
    stp = (s_req == 0) ? 1 : s_req;
    v   = m_duty[i];
    t0  = a - (a % P) + P - 1;
    if (t0 <= a) t0 += P;
    n = 0;
    while (v != tgt) begin
      n++;
      if (tgt > v) v = (v + stp >= tgt) ? tgt : v + stp;
      else         v = (v <= tgt + stp) ? tgt : v - stp;
      sch_cyc[i][n-1] = t0 + (n * hold_of(i) - 1) * P + 1;
      sch_val[i][n-1] = v;
    end
    sch_n[i] = n; sch_k[i] = 0;
    busy_from[i] = a + 1;
    ramp_to[i]   = (n == 0) ? a : sch_cyc[i][n-1];
    done_cyc[i]  = ramp_to[i] + 1;
    busy_to[i]   = done_cyc[i];
  endtask

  task automatic model_abort(input int i, input int c);
    while (sch_n[i] > sch_k[i] && sch_cyc[i][sch_n[i]-1] > c) sch_n[i]--;
    ramp_to[i] = c; busy_to[i] = c; done_cyc[i] = -1;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      bit el;
      el = 1'b0;
      if (sch_k[i] < sch_n[i] && sch_cyc[i][sch_k[i]] == cyc) begin
        el = 1'b1;
        m_duty[i] = sch_val[i][sch_k[i]];
        sch_k[i]++;
      end
      check($sformatf("dut%0d load", i), load[i], el);
      check($sformatf("dut%0d duty", i), duty[i], m_duty[i]);
      check($sformatf("dut%0d done", i), done[i], cyc == done_cyc[i]);
      check($sformatf("dut%0d busy", i), busy[i], m_busy(i, cyc));
      check($sformatf("dut%0d req_ready", i), ready[i], !m_busy(i, cyc));
      if (load[i] === 1'b1) begin
        if (nobs[i] < 16) obs[i][nobs[i]] = duty[i];
        nobs[i]++;
      end
      if (done[i] === 1'b1) done_seen[i] = 1'b1;
    end
  endtask

  // Inputs are set at the negedge; they are sampled at the next posedge and
  // outputs are compared at the following negedge.
  task automatic step();
    bit acc[2];
    bit ab[2];
    for (int i = 0; i < 2; i++) begin
      acc[i] = rv[i] && !m_busy(i, cyc);
      ab[i]  = abort && (cyc >= busy_from[i]) && (cyc <= ramp_to[i]);
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (ab[i])  model_abort(i, cyc - 1);
      if (acc[i]) model_accept(i, cyc - 1, rt, rs);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_reset(input int ncyc);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d reset load", i), load[i], 0);
      check($sformatf("dut%0d reset duty", i), duty[i], 0);
      check($sformatf("dut%0d reset busy", i), busy[i], 0);
      check($sformatf("dut%0d reset done", i), done[i], 0);
      check($sformatf("dut%0d reset req_ready", i), ready[i], 1);
    end
    repeat (ncyc) @(negedge clk);
    model_reset();
    rst = 1'b1;
    cyc = 0;
    check_outputs();
  endtask

  function automatic vec_t mk(input int inst, input int tgt, input int stp, input int n,
                              input int l0, input int l1, input int l2, input int l3,
                              input int fin, input bit poke);
    vec_t m;
    m.inst = inst; m.tgt = tgt; m.stp = stp; m.n = n;
    m.loads[0] = 8'(l0); m.loads[1] = 8'(l1); m.loads[2] = 8'(l2); m.loads[3] = 8'(l3);
    m.fin = fin; m.poke = poke;
    return m;
  endfunction

  task automatic run_vec(input vec_t v);
    int i, n;
    i = v.inst;
    nobs[i] = 0; done_seen[i] = 1'b0;
    rv[i] = 1'b1; rt = 8'(v.tgt); rs = 8'(v.stp);
    step();
    rv[i] = 1'b0;
    n = 0;
    while (!done_seen[i] && n < 2000) begin
      rv[i] = v.poke && (n % 37 == 5);
      if (rv[i]) rt = 8'd10;
      step();
      n++;
    end
    rv[i] = 1'b0;
    check($sformatf("vec tgt=%0d done reached", v.tgt), done_seen[i], 1);
    check($sformatf("vec tgt=%0d load count", v.tgt), nobs[i], v.n);
    for (int k = 0; k < v.n && k < 4; k++)
      check($sformatf("vec tgt=%0d load %0d value", v.tgt, k), obs[i][k], v.loads[k]);
    check($sformatf("vec tgt=%0d final duty", v.tgt), duty[i], v.fin);
    step();
    step();
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    nchk = 0; nerr = 0; cyc = 0;
    rv[0] = 1'b0; rv[1] = 1'b0; rt = '0; rs = '0; abort = 1'b0;
    nobs[0] = 0; nobs[1] = 0; done_seen[0] = 1'b0; done_seen[1] = 1'b0;
    model_reset();

    vecs[0] = mk(0,  20,   5, 4,   5, 10, 15, 20,  20, 1'b0);
    vecs[1] = mk(0,   3,   7, 3,  13,  6,  3,  0,   3, 1'b0);
    vecs[2] = mk(0, 150, 200, 1, 100,  0,  0,  0, 100, 1'b0);
    vecs[3] = mk(0, 102,   0, 0,   0,  0,  0,  0, 100, 1'b0);
    vecs[4] = mk(1,  75,  25, 3,  25, 50, 75,  0,  75, 1'b1);

    #2;
    apply_reset(20);
    repeat (1000) step();

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Reset in the middle of a 0 -> 75 ramp, right after the load of 50.
    apply_reset(3);
    nobs[0] = 0;
    rv[0] = 1'b1; rt = 8'd75; rs = 8'd25;
    step();
    rv[0] = 1'b0;
    n = 0;
    while (nobs[0] < 2 && n < 1000) begin step(); n++; end
    check("mid-ramp second load seen", nobs[0], 2);
    check("mid-ramp duty before reset", duty[0], 50);
    apply_reset(5);
    repeat (300) step();

`ifdef PWM_RAMP_ABORT_EN
    nobs[0] = 0; done_seen[0] = 1'b0;
    rv[0] = 1'b1; rt = 8'd75; rs = 8'd25;
    step();
    rv[0] = 1'b0;
    n = 0;
    while (nobs[0] < 2 && n < 1000) begin step(); n++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (400) step();
    check("abort duty held", duty[0], 50);
    check("abort load count", nobs[0], 2);
    check("abort no done", done_seen[0], 0);
    check("abort req_ready", ready[0], 1);
`endif

    repeat (30000) begin
      rv[0] = ($urandom_range(0, 39) == 0);
      rv[1] = ($urandom_range(0, 39) == 0);
      rt    = 8'($urandom_range(0, 255));
      rs    = 8'($urandom_range(0, 90));
`ifdef PWM_RAMP_ABORT_EN
      abort = ($urandom_range(0, 299) == 0);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
